// File: rtl/updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_p
// Description : Bounded up/down counter (0..MAX_VALUE) with netted incr/decr,
//               load clamping, overflow/underflow pulses and a sticky error.
//               Wrap mode by default; define UPDOWN_COUNTER_SAT_EN to saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_p #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned INCR_WIDTH = 4,
    parameter int unsigned DECR_WIDTH = 4,
    parameter int unsigned MAX_VALUE  = (2**WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reinit_i,
    input  logic                  incr_valid_i,
    input  logic [INCR_WIDTH-1:0] incr_i,
    input  logic                  decr_valid_i,
    input  logic [DECR_WIDTH-1:0] decr_i,
    input  logic [WIDTH-1:0]      initial_value_i,
    output logic [WIDTH-1:0]      value_o,
    output logic [WIDTH-1:0]      value_next_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  err_sticky_o
);

    // Two guard bits hold both 2*MAX_VALUE and the negative excursion.
    localparam int unsigned          SW      = WIDTH + 2;
    localparam logic [WIDTH-1:0]     C_MAX_W = WIDTH'(MAX_VALUE);
    localparam logic signed [SW-1:0] C_MAX_S = $signed(SW'(MAX_VALUE));
    localparam logic signed [SW-1:0] C_MOD_S = $signed(SW'(MAX_VALUE + 1));

    logic [WIDTH-1:0]      init_c;
    logic [WIDTH-1:0]      base;
    logic [INCR_WIDTH-1:0] inc;
    logic [DECR_WIDTH-1:0] dec;
    logic signed [SW-1:0]  sum;
    logic signed [SW-1:0]  sum_wrap_hi;
    logic signed [SW-1:0]  sum_wrap_lo;
    logic                  ovf_d;
    logic                  unf_d;
    logic [WIDTH-1:0]      value_d;

    logic [WIDTH-1:0]      value_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  err_q;

    always_comb begin
        init_c      = (initial_value_i > C_MAX_W) ? C_MAX_W : initial_value_i;
        base        = reinit_i ? init_c : value_q;
        inc         = incr_valid_i ? incr_i : '0;
        dec         = decr_valid_i ? decr_i : '0;
        sum         = $signed(SW'(base)) + $signed(SW'(inc)) - $signed(SW'(dec));
        sum_wrap_hi = sum - C_MOD_S;
        sum_wrap_lo = sum + C_MOD_S;
        unf_d       = sum[SW-1];
        ovf_d       = !unf_d && (sum > C_MAX_S);
        value_d     = sum[WIDTH-1:0];
`ifdef UPDOWN_COUNTER_SAT_EN
        if (ovf_d) begin
            value_d = C_MAX_W;
        end else if (unf_d) begin
            value_d = '0;
        end
`else
        if (ovf_d) begin
            value_d = sum_wrap_hi[WIDTH-1:0];
        end else if (unf_d) begin
            value_d = sum_wrap_lo[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= init_c;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            // A same-cycle event beats the reinit clear.
            err_q   <= ovf_d | unf_d | (err_q & ~reinit_i);
        end
    end

    assign value_o      = value_q;
    assign value_next_o = value_d;
    assign overflow_o   = ovf_q;
    assign underflow_o  = unf_q;
    assign err_sticky_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_p
// Description : Directed bench for updown_counter_p (WIDTH=4, MAX_VALUE=9).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_p;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       reinit;
    logic       incr_valid;
    logic [1:0] incr;
    logic       decr_valid;
    logic [1:0] decr;
    logic [3:0] init_val;
    logic [3:0] value;
    logic [3:0] value_next;
    logic       overflow;
    logic       underflow;
    logic       err_sticky;

    int n_cmp  = 0;
    int n_fail = 0;

    updown_counter_p #(
        .WIDTH      (4),
        .INCR_WIDTH (2),
        .DECR_WIDTH (2),
        .MAX_VALUE  (9)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .reinit_i        (reinit),
        .incr_valid_i    (incr_valid),
        .incr_i          (incr),
        .decr_valid_i    (decr_valid),
        .decr_i          (decr),
        .initial_value_i (init_val),
        .value_o         (value),
        .value_next_o    (value_next),
        .overflow_o      (overflow),
        .underflow_o     (underflow),
        .err_sticky_o    (err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] md(input logic [3:0] w, input logic [3:0] s);
        return SAT ? s : w;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ri, input logic iv, input logic [1:0] ia,
                         input logic dv, input logic [1:0] da, input logic [3:0] iv0);
        rst = r; reinit = ri; incr_valid = iv; incr = ia;
        decr_valid = dv; decr = da; init_val = iv0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input string tag, input logic [3:0] v, input logic o,
                        input logic u, input logic e);
        check({tag, ".value"}, 8'(value), 8'(v));
        check({tag, ".ovf"},   8'(overflow), 8'(o));
        check({tag, ".unf"},   8'(underflow), 8'(u));
        check({tag, ".err"},   8'(err_sticky), 8'(e));
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 4'd15);
        tick();
        regs("rst_clamp", 4'd9, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 4'd0);
        check("hold.vn", 8'(value_next), 8'd9);
        tick();
        regs("hold", 4'd9, 0, 0, 0);

        drive(0, 1, 0, 0, 0, 0, 4'd8);
        check("load8.vn", 8'(value_next), 8'd8);
        tick();
        regs("load8", 4'd8, 0, 0, 0);

        drive(0, 0, 1, 2'd3, 0, 0, 4'd0);
        check("ovf.vn", 8'(value_next), 8'(md(4'd1, 4'd9)));
        tick();
        regs("ovf", md(4'd1, 4'd9), 1, 0, 1);

        drive(0, 0, 0, 0, 0, 0, 4'd0);
        tick();
        regs("ovf_pulse_end", md(4'd1, 4'd9), 0, 0, 1);

        drive(0, 1, 0, 0, 0, 0, 4'd1);
        tick();
        regs("load1", 4'd1, 0, 0, 0);

        drive(0, 0, 0, 0, 1, 2'd3, 4'd0);
        check("unf.vn", 8'(value_next), 8'(md(4'd8, 4'd0)));
        tick();
        regs("unf", md(4'd8, 4'd0), 0, 1, 1);

        drive(0, 0, 0, 0, 0, 0, 4'd0);
        tick();
        regs("unf_pulse_end", md(4'd8, 4'd0), 0, 0, 1);

        drive(0, 1, 0, 0, 0, 0, 4'd9);
        tick();
        regs("load9", 4'd9, 0, 0, 0);

        // Net of +2/-2 at MAX must not raise an intermediate overflow.
        drive(0, 0, 1, 2'd2, 1, 2'd2, 4'd0);
        check("net0.vn", 8'(value_next), 8'd9);
        tick();
        regs("net0", 4'd9, 0, 0, 0);

        drive(0, 0, 1, 2'd3, 0, 0, 4'd0);
        check("ovf2.vn", 8'(value_next), 8'(md(4'd2, 4'd9)));
        tick();
        regs("ovf2", md(4'd2, 4'd9), 1, 0, 1);

        drive(0, 0, 1, 2'd2, 1, 2'd2, 4'd0);
        check("net_err.vn", 8'(value_next), 8'(md(4'd2, 4'd9)));
        tick();
        regs("net_err", md(4'd2, 4'd9), 0, 0, 1);

        drive(0, 1, 1, 2'd1, 0, 0, 4'd3);
        check("reinit_inc.vn", 8'(value_next), 8'd4);
        tick();
        regs("reinit_inc", 4'd4, 0, 0, 0);

        drive(0, 1, 1, 2'd3, 0, 0, 4'd9);
        check("reinit_ovf.vn", 8'(value_next), 8'(md(4'd2, 4'd9)));
        tick();
        regs("reinit_ovf", md(4'd2, 4'd9), 1, 0, 1);

        drive(0, 1, 0, 0, 0, 0, 4'd12);
        check("reinit_clamp.vn", 8'(value_next), 8'd9);
        tick();
        regs("reinit_clamp", 4'd9, 0, 0, 0);

        drive(0, 0, 0, 0, 1, 2'd2, 4'd0);
        check("dec2.vn", 8'(value_next), 8'd7);
        tick();
        regs("dec2", 4'd7, 0, 0, 0);

        drive(0, 0, 1, 2'd2, 0, 0, 4'd0);
        check("to_max.vn", 8'(value_next), 8'd9);
        tick();
        regs("to_max", 4'd9, 0, 0, 0);

        drive(0, 1, 0, 0, 1, 2'd2, 4'd2);
        check("to_zero.vn", 8'(value_next), 8'd0);
        tick();
        regs("to_zero", 4'd0, 0, 0, 0);

        drive(0, 0, 0, 0, 1, 2'd1, 4'd0);
        check("unf1.vn", 8'(value_next), 8'(md(4'd9, 4'd0)));
        tick();
        regs("unf1", md(4'd9, 4'd0), 0, 1, 1);

        // rst beats reinit/incr; value_next still follows the inputs.
        drive(1, 1, 1, 2'd3, 0, 0, 4'd9);
        check("rst_prio.vn", 8'(value_next), 8'(md(4'd2, 4'd9)));
        tick();
        regs("rst_prio", 4'd9, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 4'd0);
        tick();
        regs("post_rst", 4'd9, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
